// File: rtl/fht_in_buf.sv
// fht_in_buf: collects 16 serial chips into a shadow bank and presents them as a held parallel frame; FHT_IN_SAT_EN clamps the most negative code
module fht_in_buf #(
    parameter int DW  = 12,
    parameter int FCW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [DW-1:0] Din,
    input  logic          DinValid,
    input  logic          SymStart,
    output logic [DW-1:0] Out0,
    output logic [DW-1:0] Out1,
    output logic [DW-1:0] Out2,
    output logic [DW-1:0] Out3,
    output logic [DW-1:0] Out4,
    output logic [DW-1:0] Out5,
    output logic [DW-1:0] Out6,
    output logic [DW-1:0] Out7,
    output logic [DW-1:0] Out8,
    output logic [DW-1:0] Out9,
    output logic [DW-1:0] Out10,
    output logic [DW-1:0] Out11,
    output logic [DW-1:0] Out12,
    output logic [DW-1:0] Out13,
    output logic [DW-1:0] Out14,
    output logic [DW-1:0] Out15,
    output logic          FhtStar,
    output logic          FrameErr,
    output logic [FCW-1:0] FrameCnt
);
    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_nxt;
    logic [3:0] idx, idx_nxt, wr_addr;
    logic [DW-1:0] din_s;
    logic [DW-1:0] shadow [16];
    logic [DW-1:0] out_r [16];
    logic done, err, wr;
`ifdef FHT_IN_SAT_EN
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    assign din_s = (Din == MOST_NEG) ? MOST_NEG + 1'b1 : Din;
`else
    assign din_s = Din;
`endif
    // next state, write index and frame completion/error decode
    always_comb begin
        state_nxt = state;
        idx_nxt = idx;
        done = 1'b0;
        err = 1'b0;
        wr = 1'b0;
        wr_addr = SymStart ? 4'd0 : idx;
        if (state == IDLE) begin
            state_nxt = SymStart ? FILL : IDLE;
            wr = SymStart && DinValid;
            idx_nxt = (SymStart && DinValid) ? 4'd1 : 4'd0;
        end else begin
            done = DinValid && idx == 4'd15;
            err = SymStart && !done && idx != 4'd0;
            wr = DinValid && !done;
            idx_nxt = done ? 4'd0 : SymStart ? {3'b0, DinValid} : idx + {3'b0, DinValid};
        end
    end
    // control state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            idx <= '0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
        end
    end
    // shadow bank fill, output bank transfer on completion, status pulses and frame count
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 16; k++) begin
                shadow[k] <= '0;
                out_r[k] <= '0;
            end
            FhtStar <= 1'b0;
            FrameErr <= 1'b0;
            FrameCnt <= '0;
        end else begin
            if (wr) shadow[wr_addr] <= din_s;
            if (done) begin
                for (int k = 0; k < 15; k++) out_r[k] <= shadow[k];
                out_r[15] <= din_s;
            end
            FhtStar <= done;
            FrameErr <= err;
            FrameCnt <= FrameCnt + FCW'(done);
        end
    end
    assign Out0 = out_r[0];
    assign Out1 = out_r[1];
    assign Out2 = out_r[2];
    assign Out3 = out_r[3];
    assign Out4 = out_r[4];
    assign Out5 = out_r[5];
    assign Out6 = out_r[6];
    assign Out7 = out_r[7];
    assign Out8 = out_r[8];
    assign Out9 = out_r[9];
    assign Out10 = out_r[10];
    assign Out11 = out_r[11];
    assign Out12 = out_r[12];
    assign Out13 = out_r[13];
    assign Out14 = out_r[14];
    assign Out15 = out_r[15];
endmodule

// File: tb/tb_fht_in_buf.sv
// tb_fht_in_buf: randomized and directed checks of fht_in_buf against a queue-based frame model
module tb_fht_in_buf;
    localparam int DW = 12;
    localparam int FCW = 8;
    logic Clk = 1'b0, Reset = 1'b0, DinValid = 1'b0, SymStart = 1'b0;
    logic [DW-1:0] Din = '0;
    logic [DW-1:0] Out0, Out1, Out2, Out3, Out4, Out5, Out6, Out7;
    logic [DW-1:0] Out8, Out9, Out10, Out11, Out12, Out13, Out14, Out15;
    logic FhtStar, FrameErr;
    logic [FCW-1:0] FrameCnt;
    logic [15:0][DW-1:0] dout;
    int checks = 0, errors = 0;
    bit m_act;
    logic [DW-1:0] q[$];
    logic [15:0][DW-1:0] m_out;
    logic m_star, m_err;
    logic [FCW-1:0] m_cnt;

    fht_in_buf #(.DW(DW), .FCW(FCW)) dut (
        .Clk(Clk), .Reset(Reset), .Din(Din), .DinValid(DinValid), .SymStart(SymStart),
        .Out0(Out0), .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4), .Out5(Out5),
        .Out6(Out6), .Out7(Out7), .Out8(Out8), .Out9(Out9), .Out10(Out10), .Out11(Out11),
        .Out12(Out12), .Out13(Out13), .Out14(Out14), .Out15(Out15),
        .FhtStar(FhtStar), .FrameErr(FrameErr), .FrameCnt(FrameCnt)
    );

    assign dout = {Out15, Out14, Out13, Out12, Out11, Out10, Out9, Out8,
                   Out7, Out6, Out5, Out4, Out3, Out2, Out1, Out0};

    always #5 Clk = ~Clk;

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef FHT_IN_SAT_EN
        return (d == {1'b1, {(DW-1){1'b0}}}) ? d + 1'b1 : d;
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_act = 0;
        q.delete();
        m_out = '0;
        m_star = 0;
        m_err = 0;
        m_cnt = '0;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [DW-1:0] d);
        m_star = 0;
        m_err = 0;
        if (!m_act) begin
            if (s) begin
                m_act = 1;
                q.delete();
                if (v) q.push_back(stored(d));
            end
        end else if (v && q.size() == 15) begin
            for (int k = 0; k < 15; k++) m_out[k] = q[k];
            m_out[15] = stored(d);
            m_star = 1;
            m_cnt++;
            q.delete();
        end else if (s) begin
            if (q.size() != 0) m_err = 1;
            q.delete();
            if (v) q.push_back(stored(d));
        end else if (v) begin
            q.push_back(stored(d));
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [DW-1:0] d);
        SymStart = s;
        DinValid = v;
        Din = d;
        model_step(s, v, d);
        @(posedge Clk);
        #1;
        SymStart = 0;
        DinValid = 0;
    endtask

    task automatic test_reset();
        #1 Reset = 1;
        #1;
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", dout); end
        checks++; if (FhtStar !== 1'b0) begin errors++; $display("FAIL reset_star got %b exp 0", FhtStar); end
        checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", FrameErr); end
        checks++; if (FrameCnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", FrameCnt); end
        model_reset();
        @(posedge Clk);
        #1 Reset = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, DW'(i + 1));
            checks++; if (FhtStar !== 1'b0) begin errors++; $display("FAIL idle_star cyc %0d got %b exp 0", i, FhtStar); end
        end
    endtask

    task automatic test_basic();
        logic [15:0][DW-1:0] ramp;
        for (int k = 0; k < 16; k++) ramp[k] = DW'(k);
        for (int i = 0; i < 16; i++) begin
            cyc(i == 0, 1, DW'(i));
            if (i < 15) begin
                checks++; if (FhtStar !== 1'b0) begin errors++; $display("FAIL basic_early_star i %0d got %b exp 0", i, FhtStar); end
            end
        end
        checks++; if (FhtStar !== 1'b1) begin errors++; $display("FAIL basic_star got %b exp 1", FhtStar); end
        checks++; if (dout !== ramp) begin errors++; $display("FAIL basic_out got %h exp %h", dout, ramp); end
        checks++; if (FrameCnt !== 8'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", FrameCnt); end
        for (int i = 0; i < 15; i++) begin
            cyc(0, 1, DW'($urandom));
            checks++; if (FhtStar !== 1'b0 || dout !== ramp) begin errors++; $display("FAIL basic_hold i %0d star %b out %h exp %h", i, FhtStar, dout, ramp); end
        end
        cyc(0, 1, DW'($urandom));
        checks++; if (FhtStar !== m_star || dout !== m_out) begin errors++; $display("FAIL basic_frame2 star %b out %h exp %h", FhtStar, dout, m_out); end
    endtask

    task automatic test_gaps();
        logic [15:0][DW-1:0] ramp;
        for (int k = 0; k < 16; k++) ramp[k] = DW'(k);
        for (int i = 0; i < 16; i++) begin
            cyc(i == 0, 1, DW'(i));
            if (i == 0) begin
                checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL gap_boundary_err got %b exp 0", FrameErr); end
            end
            if (i < 15) begin
                cyc(0, 0, DW'($urandom));
                checks++; if (FhtStar !== 1'b0) begin errors++; $display("FAIL gap_star i %0d got %b exp 0", i, FhtStar); end
            end
        end
        checks++; if (FhtStar !== 1'b1) begin errors++; $display("FAIL gap_done_star got %b exp 1", FhtStar); end
        checks++; if (dout !== ramp) begin errors++; $display("FAIL gap_out got %h exp %h", dout, ramp); end
        checks++; if (FrameCnt !== 8'd3) begin errors++; $display("FAIL gap_cnt got %0d exp 3", FrameCnt); end
        cyc(0, 0, '0);
        checks++; if (FhtStar !== 1'b0) begin errors++; $display("FAIL gap_pulse_len got %b exp 0", FhtStar); end
    endtask

    task automatic test_symstart_err();
        logic [15:0][DW-1:0] prev, exp_v;
        prev = dout;
        for (int i = 0; i < 9; i++) cyc(i == 0, 1, DW'(50 + i));
        cyc(1, 0, '0);
        checks++; if (FrameErr !== 1'b1) begin errors++; $display("FAIL serr_err got %b exp 1", FrameErr); end
        checks++; if (FhtStar !== 1'b0) begin errors++; $display("FAIL serr_star got %b exp 0", FhtStar); end
        checks++; if (dout !== prev || FrameCnt !== 8'd3) begin errors++; $display("FAIL serr_hold out %h cnt %0d exp %h 3", dout, FrameCnt, prev); end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, DW'(100 + i));
            exp_v[i] = DW'(100 + i);
            if (i == 0) begin
                checks++; if (FrameErr !== 1'b0) begin errors++; $display("FAIL serr_pulse_len got %b exp 0", FrameErr); end
            end
        end
        checks++; if (FhtStar !== 1'b1 || dout !== exp_v) begin errors++; $display("FAIL serr_frame star %b out %h exp %h", FhtStar, dout, exp_v); end
    endtask

    task automatic test_sat();
        logic [DW-1:0] exp3;
`ifdef FHT_IN_SAT_EN
        exp3 = 12'h801;
`else
        exp3 = 12'h800;
`endif
        for (int i = 0; i < 16; i++) cyc(i == 0, 1, i == 3 ? 12'h800 : i == 5 ? 12'h7FF : DW'($urandom));
        checks++; if (Out3 !== exp3) begin errors++; $display("FAIL sat_out3 got %h exp %h", Out3, exp3); end
        checks++; if (Out5 !== 12'h7FF) begin errors++; $display("FAIL sat_out5 got %h exp 7ff", Out5); end
        checks++; if (dout !== m_out) begin errors++; $display("FAIL sat_model got %h exp %h", dout, m_out); end
    endtask

    task automatic test_reset_midfill();
        for (int i = 0; i < 7; i++) cyc(i == 0, 1, DW'($urandom));
        #2 Reset = 1;
        #1;
        checks++; if (dout !== '0 || FrameCnt !== '0 || FhtStar !== 1'b0 || FrameErr !== 1'b0) begin errors++; $display("FAIL midreset out %h cnt %0d star %b err %b exp all 0", dout, FrameCnt, FhtStar, FrameErr); end
        model_reset();
        @(posedge Clk);
        #1 Reset = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, DW'($urandom));
            checks++; if (FhtStar !== 1'b0 || dout !== '0) begin errors++; $display("FAIL midreset_nosym i %0d star %b out %h exp 0", i, FhtStar, dout); end
        end
    endtask

    task automatic test_wrap_coincide();
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 16; i++) cyc(f == 0 && i == 0, 1, DW'($urandom));
            checks++; if (FhtStar !== 1'b1 || dout !== m_out || FrameCnt !== m_cnt) begin errors++; $display("FAIL wrap_frame %0d star %b cnt %0d exp %0d", f, FhtStar, FrameCnt, m_cnt); end
            if (f == 254) begin
                checks++; if (FrameCnt !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", FrameCnt); end
            end
        end
        checks++; if (FrameCnt !== 8'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", FrameCnt); end
        for (int i = 0; i < 15; i++) cyc(0, 1, DW'($urandom));
        cyc(1, 1, DW'($urandom));
        checks++; if (FhtStar !== 1'b1 || FrameErr !== 1'b0) begin errors++; $display("FAIL coincide star %b err %b exp 1 0", FhtStar, FrameErr); end
        checks++; if (dout !== m_out) begin errors++; $display("FAIL coincide_out got %h exp %h", dout, m_out); end
        for (int i = 0; i < 16; i++) cyc(0, 1, DW'($urandom));
        checks++; if (FhtStar !== 1'b1 || dout !== m_out) begin errors++; $display("FAIL coincide_next star %b out %h exp %h", FhtStar, dout, m_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 15) == 0 ? 12'h800 : DW'($urandom));
            checks++; if (FhtStar !== m_star) begin errors++; $display("FAIL rnd_star cyc %0d got %b exp %b", i, FhtStar, m_star); end
            checks++; if (FrameErr !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", i, FrameErr, m_err); end
            checks++; if (FrameCnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, FrameCnt, m_cnt); end
            checks++; if (dout !== m_out) begin errors++; $display("FAIL rnd_out cyc %0d got %h exp %h", i, dout, m_out); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_symstart_err();
        test_sat();
        test_reset_midfill();
        test_wrap_coincide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
